// File: rtl/seq_pkg.sv
// Shared types for the short-read scan datapath: base codes and controller states.
package seq_pkg;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'b00;
    localparam base_t BASE_C = 2'b01;
    localparam base_t BASE_G = 2'b10;
    localparam base_t BASE_T = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } state_t;

endpackage

// File: rtl/base_mismatch_count.sv
// Combinational window-vs-read comparator: per-base mismatch bits and their popcount.
module base_mismatch_count
    import seq_pkg::*;
#(
    parameter int unsigned READ_LEN = 8,
    parameter int unsigned MW       = $clog2(READ_LEN + 1)
) (
    input  logic [2*READ_LEN-1:0] win,
    input  logic [2*READ_LEN-1:0] read_bases,
    output logic [MW-1:0]         mm
);

    base_t               diff [READ_LEN];
    logic [READ_LEN-1:0] mm_bits;

    // A base mismatches when either bit of its 2-bit code differs.
    always_comb begin
        mm_bits = '0;
        for (int j = 0; j < READ_LEN; j++) begin
            diff[j]    = base_t'(win[2*j +: 2] ^ read_bases[2*j +: 2]);
            mm_bits[j] = |diff[j];
        end
    end

    // Popcount of the mismatch bits.
    always_comb begin
        mm = '0;
        for (int j = 0; j < READ_LEN; j++) begin
            mm = mm + MW'(mm_bits[j]);
        end
    end

endmodule

// File: rtl/read_scan_ctrl.sv
// Scan sequencer: streams reference bases through a READ_LEN-wide window and
// reports every window position within MAX_MISMATCH of the loaded read.
module read_scan_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned READ_LEN     = 8,
    parameter int unsigned MAX_MISMATCH = 1,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned MW           = $clog2(READ_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*READ_LEN-1:0] read_bases,
    input  logic [ADDR_W-1:0]     ref_len,
    output logic                  ref_rd,
    output logic [ADDR_W-1:0]     ref_addr,
    input  logic [1:0]            ref_base,
    output logic                  hit_valid,
    input  logic                  hit_ready,
    output logic [ADDR_W-1:0]     hit_pos,
    output logic [MW-1:0]         hit_mm,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_W-1:0]     WIN_LEN    = ADDR_W'(READ_LEN);
    localparam logic [ADDR_W-1:0]     WIN_LEN_M1 = ADDR_W'(READ_LEN - 1);
    localparam logic [2*READ_LEN-1:0] WIN_CLEAR  = {READ_LEN{BASE_A}};

    state_t                state_q, state_d;
    logic [2*READ_LEN-1:0] read_q;
    logic [ADDR_W-1:0]     len_q;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [2*READ_LEN-1:0] win_q, win_d;
    logic                  rd_q;
    logic                  skid_v_q, skid_v_d;
    base_t                 skid_q, skid_d;
    logic                  hit_v_q, hit_v_d;
    logic [ADDR_W-1:0]     pos_q, pos_d;
    logic [MW-1:0]         mm_q, mm_d;

    logic                  start_ok;
    base_t                 in_base;
    logic                  avail;
    logic                  shift_en;
    logic [2*READ_LEN-1:0] win_next;
    logic [ADDR_W-1:0]     cnt_inc;
    logic [MW-1:0]         win_mm;
    logic                  mm_ok;
    logic                  hit_load;

    assign start_ok = start && (state_q == StIdle);

    // The skid is older than anything on ref_base, so it is consumed first.
    assign in_base  = skid_v_q ? skid_q : base_t'(ref_base);
    assign avail    = skid_v_q || rd_q;
    assign shift_en = avail && (!hit_v_q || hit_ready);
    assign win_next = {in_base, win_q[2*READ_LEN-1:2]};
    assign cnt_inc  = cnt_q + 1'b1;
    assign mm_ok    = (32'(win_mm) <= MAX_MISMATCH);
    assign hit_load = shift_en && (cnt_inc >= WIN_LEN) && mm_ok;

    // The window is evaluated as it will look after this shift.
    base_mismatch_count #(
        .READ_LEN (READ_LEN),
        .MW       (MW)
    ) u_mm (
        .win        (win_next),
        .read_bases (read_q),
        .mm         (win_mm)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read issue and status outputs.
    always_comb begin
        state_d = state_q;
        ref_rd  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (ref_len == '0) ? StDone : StScan;
                end
            end
            StScan: begin
                busy = 1'b1;
                // Never issue while the skid holds a base or a hit is stalled:
                // at most one base can then be in flight, which the skid absorbs.
                ref_rd = (addr_q < len_q) && !skid_v_q && !(hit_v_q && !hit_ready);
                if (ref_rd && ((addr_q + 1'b1) == len_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (!rd_q && !skid_v_q && !hit_v_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next-state logic for address, window, skid and hit register.
    always_comb begin
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        hit_v_d  = hit_v_q;
        pos_d    = pos_q;
        mm_d     = mm_q;

        if (start_ok) begin
            addr_d   = '0;
            cnt_d    = '0;
            win_d    = WIN_CLEAR;
            skid_v_d = 1'b0;
        end else begin
            if (ref_rd) begin
                addr_d = addr_q + 1'b1;
            end
            if (shift_en) begin
                win_d = win_next;
                cnt_d = cnt_inc;
            end
            if (skid_v_q) begin
                if (shift_en) begin
                    skid_v_d = rd_q;
                    skid_d   = base_t'(ref_base);
                end
            end else if (rd_q && !shift_en) begin
                skid_v_d = 1'b1;
                skid_d   = base_t'(ref_base);
            end
        end

        // A load can coincide with the transfer of the previous hit.
        if (hit_load) begin
            hit_v_d = 1'b1;
            pos_d   = cnt_q - WIN_LEN_M1;
            mm_d    = win_mm;
        end else if (hit_v_q && hit_ready) begin
            hit_v_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            win_q    <= WIN_CLEAR;
            rd_q     <= 1'b0;
            skid_v_q <= 1'b0;
            skid_q   <= BASE_A;
            hit_v_q  <= 1'b0;
            pos_q    <= '0;
            mm_q     <= '0;
        end else begin
            if (start_ok) begin
                read_q <= read_bases;
                len_q  <= ref_len;
            end
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            rd_q     <= ref_rd;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
            hit_v_q  <= hit_v_d;
            pos_q    <= pos_d;
            mm_q     <= mm_d;
        end
    end

    assign ref_addr  = addr_q;
    assign hit_valid = hit_v_q;
    assign hit_pos   = pos_q;
    assign hit_mm    = mm_q;

endmodule

// File: tb/tb_read_scan_ctrl.sv
// Directed bench for read_scan_ctrl: two instances (MAX_MISMATCH 0 and 1), READ_LEN=4.
module tb_read_scan_ctrl;
    import seq_pkg::*;

    localparam int unsigned RL  = 4;
    localparam int unsigned AW  = 10;
    localparam int unsigned MWT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*RL-1:0] read_bases;
    logic [AW-1:0] ref_len;

    logic          start     [2];
    logic          hit_ready [2];
    logic          ref_rd    [2];
    logic [AW-1:0] ref_addr  [2];
    logic [1:0]    ref_base  [2];
    logic          hit_valid [2];
    logic [AW-1:0] hit_pos   [2];
    logic [MWT-1:0] hit_mm   [2];
    logic          busy      [2];
    logic          done      [2];

    base_t mem [16];

    int checks = 0;
    int errors = 0;
    int hq_pos[$];
    int hq_mm[$];
    int exp_p[$];
    int exp_m[$];
    int rd_cnt, oob_cnt, stall_rd, done_cnt;
    int scan_len;
    int dcyc, fhv;

    always #5 clk = ~clk;

    read_scan_ctrl #(.READ_LEN(RL), .MAX_MISMATCH(0), .ADDR_W(AW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .read_bases(read_bases),
        .ref_len(ref_len), .ref_rd(ref_rd[0]), .ref_addr(ref_addr[0]),
        .ref_base(ref_base[0]), .hit_valid(hit_valid[0]), .hit_ready(hit_ready[0]),
        .hit_pos(hit_pos[0]), .hit_mm(hit_mm[0]), .busy(busy[0]), .done(done[0])
    );

    read_scan_ctrl #(.READ_LEN(RL), .MAX_MISMATCH(1), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .read_bases(read_bases),
        .ref_len(ref_len), .ref_rd(ref_rd[1]), .ref_addr(ref_addr[1]),
        .ref_base(ref_base[1]), .hit_valid(hit_valid[1]), .hit_ready(hit_ready[1]),
        .hit_pos(hit_pos[1]), .hit_mm(hit_mm[1]), .busy(busy[1]), .done(done[1])
    );

    // Synchronous reference memory: data one cycle after the strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ref_rd[i]) ref_base[i] <= mem[ref_addr[i][3:0]];
        end
    end

    // Passive monitor: hit transfers, reads, stalled reads, done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (hit_valid[i] && hit_ready[i]) begin
                    hq_pos.push_back(int'(hit_pos[i]));
                    hq_mm.push_back(int'(hit_mm[i]));
                end
                if (ref_rd[i]) begin
                    rd_cnt++;
                    if (int'(ref_addr[i]) >= scan_len) oob_cnt++;
                end
                if (hit_valid[i] && !hit_ready[i] && ref_rd[i]) stall_rd++;
                if (done[i]) done_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic base_t code(input byte c);
        case (c)
            "C":     return BASE_C;
            "G":     return BASE_G;
            "T":     return BASE_T;
            default: return BASE_A;
        endcase
    endfunction

    function automatic logic [2*RL-1:0] enc_read(input string s);
        logic [2*RL-1:0] r;
        r = '0;
        for (int j = 0; j < int'(RL); j++) r[2*j +: 2] = code(s[j]);
        return r;
    endfunction

    task automatic load_ref(input string s);
        for (int i = 0; i < 16; i++) mem[i] = BASE_A;
        for (int i = 0; i < s.len(); i++) mem[i] = code(s[i]);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check_hits(input string tag);
        check({tag, "_nhits"}, hq_pos.size(), exp_p.size());
        for (int i = 0; i < exp_p.size(); i++) begin
            check({tag, "_pos"}, qget(hq_pos, i), exp_p[i]);
            check({tag, "_mm"}, qget(hq_mm, i), exp_m[i]);
        end
    endtask

    // One scan on instance u; stall = cycles hit_ready stays low once a hit shows;
    // restart = cycle index (after t+1) at which a stray start is pulsed, -1 for none.
    task automatic run(input int u, input int stall, input int restart,
                       output int done_cyc, output int first_hv);
        int stall_cnt;
        hq_pos.delete();
        hq_mm.delete();
        rd_cnt = 0; oob_cnt = 0; stall_rd = 0; done_cnt = 0;
        scan_len = int'(ref_len);
        hit_ready[u] = (stall == 0);
        stall_cnt = 0;
        done_cyc = -1;
        first_hv = -1;
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        check("busy_t1", busy[u], 1);
        check("rd_t1", ref_rd[u], scan_len != 0);
        check("addr_t1", ref_addr[u], 0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (hit_valid[u] && first_hv < 0) first_hv = cyc;
            if (done[u]) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            start[u] = (cyc + 1 == restart);
            if (cyc + 1 == restart) begin
                read_bases = ~read_bases;
                ref_len    = 10'd2;
            end
            if (!hit_ready[u] && hit_valid[u]) begin
                if (stall_cnt == stall) hit_ready[u] = 1'b1;
                else stall_cnt++;
            end
        end
        start[u] = 1'b0;
        check("done_seen", done_cyc >= 0, 1);
        @(negedge clk);
        check("busy_after", busy[u], 0);
        check("done_once", done_cnt, 1);
        check("rd_oob", oob_cnt, 0);
        hit_ready[u] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        read_bases = '0;
        ref_len = '0;
        scan_len = 0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            hit_ready[i] = 1'b1;
        end
        load_ref("");
        @(negedge clk);
        check("rst_u0", {hit_valid[0], ref_rd[0], busy[0], done[0],
                         hit_pos[0], ref_addr[0], hit_mm[0]}, 0);
        check("rst_u1", {hit_valid[1], ref_rd[1], busy[1], done[1],
                         hit_pos[1], ref_addr[1], hit_mm[1]}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact match only, single hit at pos 2.
        read_bases = enc_read("ACGT");
        load_ref("TTACGTTT");
        ref_len = 10'd8;
        run(0, 0, -1, dcyc, fhv);
        exp_p = '{2}; exp_m = '{0};
        check_hits("t1");
        check("t1_rd", rd_cnt, 8);
        check("t1_first_hv", fhv, 7);
        check("t1_done_cyc", dcyc, 10);

        // One mismatch allowed.
        read_bases = enc_read("ACGT");
        load_ref("ACGAACGT");
        ref_len = 10'd8;
        run(1, 0, -1, dcyc, fhv);
        exp_p = '{0, 4}; exp_m = '{1, 0};
        check_hits("t2");
        check("t2_first_hv", fhv, 5);

        // Back-pressure: hit_ready low for 6 cycles after the first hit.
        read_bases = enc_read("AAAA");
        load_ref("AAAAAAA");
        ref_len = 10'd7;
        run(1, 6, -1, dcyc, fhv);
        exp_p = '{0, 1, 2, 3}; exp_m = '{0, 0, 0, 0};
        check_hits("t3");
        check("t3_rd", rd_cnt, 7);
        check("t3_stall_rd", stall_rd, 0);
        check("t3_first_hv", fhv, 5);

        // Reference shorter than the read.
        read_bases = enc_read("AAAA");
        load_ref("AAA");
        ref_len = 10'd3;
        run(1, 0, -1, dcyc, fhv);
        check("t4_rd", rd_cnt, 3);
        check("t4_nhv", fhv, -1);
        check("t4_nhits", hq_pos.size(), 0);

        // Empty reference.
        ref_len = 10'd0;
        run(1, 0, -1, dcyc, fhv);
        check("t5_rd", rd_cnt, 0);
        check("t5_done_cyc", dcyc, 0);

        // Stray start mid-scan with changed inputs.
        read_bases = enc_read("ACGT");
        load_ref("ACGAACGT");
        ref_len = 10'd8;
        run(1, 0, 3, dcyc, fhv);
        exp_p = '{0, 4}; exp_m = '{1, 0};
        check_hits("t6");
        check("t6_rd", rd_cnt, 8);

        // Asynchronous reset while a hit is held.
        read_bases = enc_read("ACGT");
        ref_len = 10'd8;
        hit_ready[1] = 1'b0;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (hit_valid[1]) break;
        end
        check("t7_hv_before", hit_valid[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_async", {hit_valid[1], ref_rd[1], busy[1], done[1],
                               hit_pos[1], ref_addr[1], hit_mm[1]}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hit_ready[1] = 1'b1;
        @(posedge clk); #1;
        run(1, 0, -1, dcyc, fhv);
        exp_p = '{0, 4}; exp_m = '{1, 0};
        check_hits("t7");
        check("t7_rd", rd_cnt, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
